// File: rtl/uart_rx_if.sv
// AXI4-Stream channel carrying one received UART character; tuser[0] flags a
// frame or parity error on that character.
interface uart_rx_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic [0:0] tuser;

   modport src (output tdata, output tvalid, output tuser, input tready);
   modport snk (input tdata, input tvalid, input tuser, output tready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversamples rxd on baud_clk ticks, deserialises LSB-first frames
// and presents each character on an AXI4-Stream source with an error flag.
module uart_rx #(
   parameter int unsigned TICKS_PER_BIT = 9,
   parameter int unsigned SAMPLE_TICK   = 4
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        En,
   input  logic        baud_clk,
   uart_rx_if.src      m_axis,
   input  logic [1:0]  data_bits,
   input  logic [1:0]  stop_bits,
   input  logic        parity_en,
   input  logic        parity_type,
   output logic        busy,
   output logic        frame_err,
   output logic        parity_err,
   output logic        overrun_err,
   input  logic        rxd
);

   localparam int unsigned CW = $clog2(TICKS_PER_BIT + 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_flag_q, par_flag_d;
   logic [3:0]      nbits_q, nbits_d;
   logic            pen_q, pen_d;
   logic            ptype_q, ptype_d;
   logic [7:0]      tdata_q, tdata_d;
   logic            tuser_q, tuser_d;
   logic            tvalid_q, tvalid_d;
   logic            frame_err_q, frame_err_d;
   logic            parity_err_q, parity_err_d;
   logic            overrun_q, overrun_d;
   logic            rxd_meta_q, rxd_sync_q;
   logic            expire;
   logic            unused_stop_bits;

   // Only the first stop bit is checked, so the stop-bit count is not needed.
   assign unused_stop_bits = ^stop_bits;

   assign expire = (cnt_q == CW'(1));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      shift_d      = shift_q;
      par_flag_d   = par_flag_q;
      nbits_d      = nbits_q;
      pen_d        = pen_q;
      ptype_d      = ptype_q;
      tdata_d      = tdata_q;
      tuser_d      = tuser_q;
      tvalid_d     = tvalid_q;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;

      if (tvalid_q && m_axis.tready) tvalid_d = 1'b0;

      if (baud_clk) begin
         unique case (state_q)
            StIdle: begin
               if (!rxd_sync_q) begin
                  state_d = StStart;
                  cnt_d   = CW'(SAMPLE_TICK);
                  nbits_d = 4'd8 - {2'b00, data_bits};
                  pen_d   = parity_en;
                  ptype_d = parity_type;
               end
            end
            StStart: begin
               if (!expire) begin
                  cnt_d = cnt_q - CW'(1);
               end else if (rxd_sync_q) begin
                  state_d = StIdle;
               end else begin
                  state_d    = StData;
                  cnt_d      = CW'(TICKS_PER_BIT);
                  idx_d      = 3'd0;
                  shift_d    = 8'h00;
                  par_flag_d = 1'b0;
               end
            end
            StData: begin
               if (!expire) begin
                  cnt_d = cnt_q - CW'(1);
               end else begin
                  shift_d[idx_q] = rxd_sync_q;
                  cnt_d          = CW'(TICKS_PER_BIT);
                  idx_d          = idx_q + 3'd1;
                  if ({1'b0, idx_q} == nbits_q - 4'd1) state_d = pen_q ? StParity : StStop;
               end
            end
            StParity: begin
               if (!expire) begin
                  cnt_d = cnt_q - CW'(1);
               end else begin
                  // Unused upper shift bits are zero, so the full-word XOR is the data XOR.
                  par_flag_d = rxd_sync_q != (^shift_q ^ ptype_q);
                  cnt_d      = CW'(TICKS_PER_BIT);
                  state_d    = StStop;
               end
            end
            StStop: begin
               if (!expire) begin
                  cnt_d = cnt_q - CW'(1);
               end else begin
                  frame_err_d  = !rxd_sync_q;
                  parity_err_d = par_flag_q;
                  state_d      = rxd_sync_q ? StIdle : StBreak;
                  if (!tvalid_q || m_axis.tready) begin
                     tdata_d  = shift_q;
                     tuser_d  = !rxd_sync_q || par_flag_q;
                     tvalid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end
            end
            StBreak: begin
               if (rxd_sync_q) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end

      if (!En) begin
         state_d      = StIdle;
         cnt_d        = '0;
         idx_d        = 3'd0;
         shift_d      = 8'h00;
         par_flag_d   = 1'b0;
         tdata_d      = 8'h00;
         tuser_d      = 1'b0;
         tvalid_d     = 1'b0;
         frame_err_d  = 1'b0;
         parity_err_d = 1'b0;
         overrun_d    = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         idx_q        <= 3'd0;
         shift_q      <= 8'h00;
         par_flag_q   <= 1'b0;
         nbits_q      <= 4'd8;
         pen_q        <= 1'b0;
         ptype_q      <= 1'b0;
         tdata_q      <= 8'h00;
         tuser_q      <= 1'b0;
         tvalid_q     <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
         rxd_meta_q   <= 1'b1;
         rxd_sync_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         par_flag_q   <= par_flag_d;
         nbits_q      <= nbits_d;
         pen_q        <= pen_d;
         ptype_q      <= ptype_d;
         tdata_q      <= tdata_d;
         tuser_q      <= tuser_d;
         tvalid_q     <= tvalid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
         rxd_meta_q   <= En ? rxd : 1'b1;
         rxd_sync_q   <= En ? rxd_meta_q : 1'b1;
      end
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tuser  = tuser_q;
   assign busy          = (state_q != StIdle);
   assign frame_err     = frame_err_q;
   assign parity_err    = parity_err_q;
   assign overrun_err   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames tick-by-tick and checks the
// stream output, busy and error pulses against hand-computed values.
module tb_uart_rx;
   localparam int TPB = 9;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       En = 1'b1;
   logic       baud_clk = 1'b0;
   logic       rxd = 1'b1;
   logic       parity_en = 1'b0;
   logic       parity_type = 1'b0;
   logic [1:0] data_bits = 2'd0;
   logic [1:0] stop_bits = 2'd0;
   logic       busy, frame_err, parity_err, overrun_err;

   uart_rx_if m_axis ();

   int         n_checks = 0;
   int         n_fail = 0;
   int         n_beats = 0, n_frame = 0, n_par = 0, n_ovr = 0;
   logic [7:0] last_data = 8'h00;
   logic       last_user = 1'b0;
   int         b, f, p, o;

   uart_rx #(.TICKS_PER_BIT(TPB), .SAMPLE_TICK(4)) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .En         (En),
      .baud_clk   (baud_clk),
      .m_axis     (m_axis),
      .data_bits  (data_bits),
      .stop_bits  (stop_bits),
      .parity_en  (parity_en),
      .parity_type(parity_type),
      .busy       (busy),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun_err(overrun_err),
      .rxd        (rxd)
   );

   always #5 Clk = ~Clk;

   // One baud tick every 4 Clk cycles.
   initial forever begin
      repeat (3) @(negedge Clk);
      baud_clk = 1'b1;
      @(negedge Clk);
      baud_clk = 1'b0;
   end

   always @(negedge Clk) begin
      if (m_axis.tvalid && m_axis.tready) begin
         n_beats++;
         last_data = m_axis.tdata;
         last_user = m_axis.tuser[0];
      end
      if (frame_err) n_frame++;
      if (parity_err) n_par++;
      if (overrun_err) n_ovr++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge Clk);
         while (!baud_clk) @(posedge Clk);
      end
      #1;
   endtask

   // Leaves rxd at the stop level; caller returns the line high.
   task automatic send(input logic [7:0] d, input int nbits, input bit pen, input bit pbit,
                       input bit stop_val, input int stop_ticks);
      rxd = 1'b0;
      ticks(TPB);
      for (int i = 0; i < nbits; i++) begin
         rxd = d[i];
         ticks(TPB);
      end
      if (pen) begin
         rxd = pbit;
         ticks(TPB);
      end
      rxd = stop_val;
      ticks(stop_ticks);
   endtask

   initial begin
      m_axis.tready = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check("reset_tvalid", 32'(m_axis.tvalid), 32'd0);
      check("reset_tdata", 32'(m_axis.tdata), 32'h00);
      check("reset_busy", 32'(busy), 32'd0);
      Rst = 1'b0;
      m_axis.tready = 1'b1;
      ticks(3);

      // Loopback 0xA5, 8N1
      b = n_beats; f = n_frame; p = n_par;
      send(8'hA5, 8, 1'b0, 1'b0, 1'b1, TPB); rxd = 1'b1;
      ticks(2);
      check("a5_beats", 32'(n_beats), 32'(b + 1));
      check("a5_data", 32'(last_data), 32'hA5);
      check("a5_user", 32'(last_user), 32'd0);
      check("a5_frame_err", 32'(n_frame), 32'(f));
      check("a5_parity_err", 32'(n_par), 32'(p));
      check("a5_busy", 32'(busy), 32'd0);

      // 7 data bits, odd parity; 0x53 has four ones so the parity bit is 1
      data_bits = 2'd1; parity_en = 1'b1; parity_type = 1'b1;
      p = n_par;
      send(8'h53, 7, 1'b1, 1'b1, 1'b1, TPB); rxd = 1'b1;
      ticks(2);
      check("par_ok_data", 32'(last_data), 32'h53);
      check("par_ok_user", 32'(last_user), 32'd0);
      send(8'h53, 7, 1'b1, 1'b0, 1'b1, TPB); rxd = 1'b1;
      ticks(2);
      check("par_bad_data", 32'(last_data), 32'h53);
      check("par_bad_user", 32'(last_user), 32'd1);
      check("par_bad_pulses", 32'(n_par), 32'(p + 1));

      // Framing error then a 30-tick break
      data_bits = 2'd0; parity_en = 1'b0; parity_type = 1'b0;
      b = n_beats; f = n_frame;
      send(8'h3C, 8, 1'b0, 1'b0, 1'b0, TPB);
      check("frm_data", 32'(last_data), 32'h3C);
      check("frm_user", 32'(last_user), 32'd1);
      check("frm_pulse", 32'(n_frame), 32'(f + 1));
      ticks(30);
      check("brk_busy", 32'(busy), 32'd1);
      check("brk_beats", 32'(n_beats), 32'(b + 1));
      rxd = 1'b1;
      ticks(3);
      check("brk_end_busy", 32'(busy), 32'd0);
      check("brk_end_beats", 32'(n_beats), 32'(b + 1));

      // Two-tick glitch is a false start
      b = n_beats;
      rxd = 1'b0; ticks(2); rxd = 1'b1; ticks(2);
      check("glitch_busy_hi", 32'(busy), 32'd1);
      ticks(4);
      check("glitch_busy_lo", 32'(busy), 32'd0);
      check("glitch_beats", 32'(n_beats), 32'(b));
      send(8'h11, 8, 1'b0, 1'b0, 1'b1, TPB); rxd = 1'b1;
      ticks(2);
      check("post_glitch_data", 32'(last_data), 32'h11);
      check("post_glitch_beats", 32'(n_beats), 32'(b + 1));

      // Overrun with tready low
      m_axis.tready = 1'b0;
      b = n_beats; o = n_ovr;
      send(8'h01, 8, 1'b0, 1'b0, 1'b1, TPB); rxd = 1'b1;
      send(8'h02, 8, 1'b0, 1'b0, 1'b1, TPB); rxd = 1'b1;
      ticks(2);
      check("ovr_tvalid", 32'(m_axis.tvalid), 32'd1);
      check("ovr_tdata", 32'(m_axis.tdata), 32'h01);
      check("ovr_pulses", 32'(n_ovr), 32'(o + 1));
      check("ovr_no_beat", 32'(n_beats), 32'(b));
      m_axis.tready = 1'b1;
      ticks(3);
      check("ovr_drain_beats", 32'(n_beats), 32'(b + 1));
      check("ovr_drain_data", 32'(last_data), 32'h01);
      check("ovr_drain_tvalid", 32'(m_axis.tvalid), 32'd0);

      // Async reset during data bit 3 of 0xFF
      rxd = 1'b0; ticks(TPB);
      rxd = 1'b1; ticks(3 * TPB + 4);
      check("rst_pre_busy", 32'(busy), 32'd1);
      #2 Rst = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
      check("rst_tdata", 32'(m_axis.tdata), 32'h00);
      check("rst_tuser", 32'(m_axis.tuser[0]), 32'd0);
      ticks(2);
      Rst = 1'b0;
      ticks(20);
      b = n_beats;
      send(8'h5A, 8, 1'b0, 1'b0, 1'b1, TPB); rxd = 1'b1;
      ticks(2);
      check("post_rst_beats", 32'(n_beats), 32'(b + 1));
      check("post_rst_data", 32'(last_data), 32'h5A);
      check("post_rst_user", 32'(last_user), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
